// File: rtl/fft_seq_pkg.sv
// rtl/fft_seq_pkg.sv - shared types, constants and helpers for the FFT frame sequencer
//
// Contents:
//   SEQ_N / FRAME   default log2 frame length and the frame length it implies
//   SEQ_MAX_N       widest frame exponent the bit-reversal helper handles
//   FPT_W           width of one fixed-point sample word (fpt)
//   seq_state_t     reader FSM states (S_IDLE, S_STREAM, S_GAP)
//   bitrev()        N-bit bit-reversal of a read pointer

package fft_seq_pkg;

    localparam int SEQ_N     = 4;
    localparam int FRAME     = 1 << SEQ_N;
    localparam int SEQ_MAX_N = 16;
    localparam int FPT_W     = 16;

    // S_ prefix keeps the state names clear of the GAP module parameter.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_GAP    = 2'd2
    } seq_state_t;

    localparam int BR_IW = $clog2(SEQ_MAX_N);

    // Reverses the low n bits of ptr; bits at or above n come back as zero.
    function automatic logic [SEQ_MAX_N-1:0] bitrev(input logic [SEQ_MAX_N-1:0] ptr,
                                                    input int n);
        logic [SEQ_MAX_N-1:0] r;
        r = '0;
        for (int i = 0; i < SEQ_MAX_N; i++) begin
            if (i < n) begin
                r[BR_IW'(i)] = ptr[BR_IW'(n - 1 - i)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_seq_bank.sv
// rtl/fft_seq_bank.sv - ping-pong sample storage with full flags and a registered read port
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   wr_valid/wr_ready   sample write handshake; wr_ready = !full[wbank]
//   wr_data             sample written at the write pointer of the write bank
//   rd_en               load rd_data from {rd_bank, rd_addr} this cycle
//   rd_bank, rd_addr    read location
//   rd_data             registered read data; holds its value when rd_en = 0
//   free                mark rd_bank empty (issued with the last read of a frame)
//   full                per-bank full flags

module fft_seq_bank
    import fft_seq_pkg::*;
#(
    parameter int N      = SEQ_N,
    parameter int DATA_W = FPT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              rd_en,
    input  logic              rd_bank,
    input  logic [N-1:0]      rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic              free,
    output logic [1:0]        full
);

    localparam int             DEPTH    = 2 * (1 << N);
    localparam logic [N-1:0]   PTR_LAST = N'((1 << N) - 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [N-1:0]      wptr;
    logic              wbank;
    logic              wr_fire;
    logic              wr_last;

    assign wr_ready = !full[wbank];
    assign wr_fire  = wr_valid && wr_ready;
    assign wr_last  = wr_fire && (wptr == PTR_LAST);

    // Storage carries no reset so it can map onto RAM; the full flags alone
    // decide what counts as valid contents.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[{wbank, wptr}] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[{rd_bank, rd_addr}];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            wbank <= 1'b0;
            full  <= 2'b00;
        end else begin
            if (wr_fire) begin
                wptr <= wptr + N'(1);
                if (wr_last) begin
                    wbank <= ~wbank;
                end
            end
            // A free of a bank wins over a fill of it; the writer then sees
            // the bank empty on the following cycle.
            for (int i = 0; i < 2; i++) begin
                if (free && (rd_bank == 1'(i))) begin
                    full[i] <= 1'b0;
                end else if (wr_last && (wbank == 1'(i))) begin
                    full[i] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fft_frame_sequencer.sv
// rtl/fft_frame_sequencer.sv - buffers a sample stream into ping-pong frames and feeds the FFT core
//
// Optional build macro: FFT_SEQ_BITREV_EN (emit each frame in bit-reversed order).
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   in_valid/in_ready   upstream sample handshake
//   in_data             upstream sample
//   run                 level enable, sampled in IDLE and at each frame/gap end
//   mode_cont           1 = frames back to back while run, 0 = one frame per run rising edge
//   start_ip            one-cycle pulse with the first sample of a frame
//   ip, ip_valid        registered sample to the FFT core; valid for 2^N cycles per frame
//   busy                reader is in STREAM or GAP
//   frame_cnt           frames fully emitted since reset (wraps)

module fft_frame_sequencer
    import fft_seq_pkg::*;
#(
    parameter int N     = SEQ_N,
    parameter int GAP   = 0,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [FPT_W-1:0] in_data,
    input  logic             run,
    input  logic             mode_cont,
    output logic             start_ip,
    output logic [FPT_W-1:0] ip,
    output logic             ip_valid,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam logic [N-1:0]  PTR_LAST = N'((1 << N) - 1);
    localparam int            GW       = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

    seq_state_t   state;
    logic         rbank;
    logic [N-1:0] rptr;
    logic [GW-1:0] gap_cnt;
    logic         run_q;
    logic         edge_lat;
    logic [1:0]   full;

    logic         run_rise;
    logic         trig;
    logic         start_cur;
    logic         start_nxt;
    logic         last_rd;
    logic         rd_en;
    logic [N-1:0] rd_ptr;
    logic [N-1:0] rd_addr;
    logic         frame_start;

    // start_cur looks at the bank currently selected for reading; start_nxt
    // looks at the other one, used on the last read when rbank is about to toggle.
    always_comb begin
        run_rise    = run && !run_q;
        trig        = mode_cont || edge_lat || run_rise;
        start_cur   = full[rbank] && run && trig;
        start_nxt   = full[~rbank] && run && trig;
        last_rd     = (state == S_STREAM) && (rptr == PTR_LAST);
        rd_en       = 1'b0;
        rd_ptr      = '0;
        frame_start = 1'b0;
        case (state)
            S_IDLE: begin
                // The first read is issued in the decision cycle so the first
                // sample lands one cycle after the decision.
                rd_en       = start_cur;
                frame_start = start_cur;
            end
            S_STREAM: begin
                rd_en       = 1'b1;
                rd_ptr      = rptr;
                frame_start = last_rd && (GAP == 0) && start_nxt;
            end
            S_GAP: begin
                frame_start = (gap_cnt == GAP_LAST) && start_cur;
            end
            default: begin
                rd_en = 1'b0;
            end
        endcase
    end

`ifdef FFT_SEQ_BITREV_EN
    assign rd_addr = N'(bitrev(SEQ_MAX_N'(rd_ptr), N));
`else
    assign rd_addr = rd_ptr;
`endif

    assign busy = (state != S_IDLE);

    fft_seq_bank #(
        .N      (N),
        .DATA_W (FPT_W)
    ) u_bank (
        .clk      (clk),
        .reset    (reset),
        .wr_valid (in_valid),
        .wr_data  (in_data),
        .wr_ready (in_ready),
        .rd_en    (rd_en),
        .rd_bank  (rbank),
        .rd_addr  (rd_addr),
        .rd_data  (ip),
        .free     (last_rd),
        .full     (full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            rbank     <= 1'b0;
            rptr      <= '0;
            gap_cnt   <= '0;
            run_q     <= 1'b0;
            edge_lat  <= 1'b0;
            start_ip  <= 1'b0;
            ip_valid  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            run_q    <= run;
            ip_valid <= rd_en;
            start_ip <= rd_en && (rd_ptr == '0);

            // A rising edge is remembered until a frame actually starts.
            if (frame_start) begin
                edge_lat <= 1'b0;
            end else if (run_rise) begin
                edge_lat <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (start_cur) begin
                        state <= S_STREAM;
                        rptr  <= N'(1);
                    end
                end
                S_STREAM: begin
                    rptr <= rptr + N'(1);
                    if (last_rd) begin
                        rbank     <= ~rbank;
                        frame_cnt <= frame_cnt + CNT_W'(1);
                        if (GAP > 0) begin
                            state   <= S_GAP;
                            gap_cnt <= '0;
                        end else if (!start_nxt) begin
                            state <= S_IDLE;
                        end
                        // Otherwise stay in STREAM; rptr wraps to 0 and the
                        // next frame follows without a bubble.
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= start_cur ? S_STREAM : S_IDLE;
                        rptr  <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// tb/tb_fft_frame_sequencer.sv - scoreboard bench for fft_frame_sequencer (GAP=0 and GAP=3 instances)

module tb_fft_frame_sequencer;
    import fft_seq_pkg::*;

    localparam int L = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0]            reset_v;
    logic [1:0]            in_valid_v;
    logic [1:0]            run_v;
    logic [1:0]            mode_v;
    logic [1:0][FPT_W-1:0] in_data_v;
    wire  [1:0]            in_ready_v;
    wire  [1:0]            start_v;
    wire  [1:0]            ipv_v;
    wire  [1:0]            busy_v;
    wire  [1:0][FPT_W-1:0] ip_v;
    wire  [1:0][15:0]      cnt_v;

    fft_frame_sequencer #(.N(4), .GAP(0), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset_v[0]), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .in_data(in_data_v[0]), .run(run_v[0]), .mode_cont(mode_v[0]), .start_ip(start_v[0]),
        .ip(ip_v[0]), .ip_valid(ipv_v[0]), .busy(busy_v[0]), .frame_cnt(cnt_v[0])
    );

    fft_frame_sequencer #(.N(4), .GAP(3), .CNT_W(16)) u_gap (
        .clk(clk), .reset(reset_v[1]), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .in_data(in_data_v[1]), .run(run_v[1]), .mode_cont(mode_v[1]), .start_ip(start_v[1]),
        .ip(ip_v[1]), .ip_valid(ipv_v[1]), .busy(busy_v[1]), .frame_cnt(cnt_v[1])
    );

    typedef struct {
        logic [FPT_W-1:0] d;
        logic             s;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   st0[$];
    int   st1[$];
    int   lastv[2];
    int   pass_cnt = 0;
    int   total_cnt = 0;

    task automatic chk(input string nm, input longint act, input longint req);
        total_cnt++;
        if (act == req) pass_cnt++;
        else $display("FAIL %s: actual %0d required %0d (cycle %0d)", nm, act, req, cyc);
    endtask

    // Emission order of frame index i: natural, or 4-bit reversed.
    function automatic int ord(input int i);
`ifdef FFT_SEQ_BITREV_EN
        return ((i & 1) << 3) | ((i & 2) << 1) | ((i & 4) >> 1) | ((i & 8) >> 3);
`else
        return i;
`endif
    endfunction

    function automatic int qsz(input int s);
        return (s != 0) ? q1.size() : q0.size();
    endfunction

    task automatic push_frame(input int s, input int base, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.d = FPT_W'(base + ord(i));
            e.s = (i == 0);
            if (s != 0) q1.push_back(e);
            else q0.push_back(e);
        end
    endtask

    task automatic push_start(input int s, input int t);
        if (s != 0) st1.push_back(t);
        else st0.push_back(t);
    endtask

    task automatic mon(input int s);
        exp_t e;
        int   t;
        if (ipv_v[s]) begin
            lastv[s] = cyc;
            if (qsz(s) == 0) begin
                chk($sformatf("unexpected_sample_u%0d", s), ip_v[s], -1);
            end else begin
                if (s != 0) e = q1.pop_front();
                else e = q0.pop_front();
                chk($sformatf("ip_u%0d", s), ip_v[s], e.d);
                chk($sformatf("start_flag_u%0d", s), start_v[s], e.s);
            end
            if (start_v[s] && ((s != 0) ? st1.size() : st0.size()) != 0) begin
                if (s != 0) t = st1.pop_front();
                else t = st0.pop_front();
                chk($sformatf("start_cycle_u%0d", s), cyc, t);
            end
        end else if (start_v[s]) begin
            chk($sformatf("start_without_valid_u%0d", s), 1, 0);
        end
    endtask

    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) mon(s);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rst(input int s);
        reset_v[s]    = 1'b1;
        in_valid_v[s] = 1'b0;
        run_v[s]      = 1'b0;
        mode_v[s]     = 1'b0;
        tick(2);
        reset_v[s]    = 1'b0;
    endtask

    task automatic burst(input int s, input int first, input int n);
        int guard;
        for (int k = 0; k < n; k++) begin
            in_data_v[s]  = FPT_W'(first + k);
            in_valid_v[s] = 1'b1;
            guard = 0;
            while (!in_ready_v[s] && guard < 200) begin
                tick(1);
                guard++;
            end
            if (guard >= 200) chk("in_ready_timeout", 0, 1);
            tick(1);
        end
        in_valid_v[s] = 1'b0;
    endtask

    task automatic drain(input int s, input int maxc);
        int k = 0;
        while ((qsz(s) != 0 || busy_v[s]) && k < maxc) begin
            tick(1);
            k++;
        end
        chk($sformatf("drain_u%0d", s), qsz(s), 0);
        chk($sformatf("starts_left_u%0d", s), (s != 0) ? st1.size() : st0.size(), 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_start_ip"}, start_v[0], 0);
        chk({tag, "_ip"}, ip_v[0], 0);
        chk({tag, "_ip_valid"}, ipv_v[0], 0);
        chk({tag, "_busy"}, busy_v[0], 0);
        chk({tag, "_frame_cnt"}, cnt_v[0], 0);
        chk({tag, "_in_ready"}, in_ready_v[0], 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1);
    end

    initial begin
        int c;
        int d;
        reset_v    = 2'b11;
        in_valid_v = 2'b00;
        run_v      = 2'b00;
        mode_v     = 2'b00;
        in_data_v  = '0;
        lastv[0]   = 0;
        lastv[1]   = 0;
        tick(3);
        reset_v = 2'b00;
        chk_reset_vals("reset");

        // Continuous feed, GAP=0: starts at +17/+33/+49, 48 contiguous samples.
        mode_v[0] = 1'b1;
        run_v[0]  = 1'b1;
        c = cyc;
        push_frame(0, 0, L);
        push_frame(0, 16, L);
        push_frame(0, 32, L);
        push_start(0, c + 17);
        push_start(0, c + 33);
        push_start(0, c + 49);
        burst(0, 0, 48);
        tick(2);
        chk("busy_streaming", busy_v[0], 1);
        drain(0, 200);
        chk("cont_frame_cnt", cnt_v[0], 3);
        chk("ip_hold_last", ip_v[0], 47);
        chk("ip_valid_idle", ipv_v[0], 0);
        chk("last_valid_cycle", lastv[0], c + 64);

        // Single shot: 32 buffered, one run pulse -> one frame.
        rst(0);
        burst(0, 0, 32);
        chk("both_full_in_ready", in_ready_v[0], 0);
        tick(3);
        chk("no_frame_without_run", ipv_v[0], 0);
        push_frame(0, 0, L);
        push_start(0, cyc + 1);
        run_v[0] = 1'b1;
        tick(1);
        run_v[0] = 1'b0;
        drain(0, 100);
        chk("single_frame_cnt", cnt_v[0], 1);
        chk("single_refill_ready", in_ready_v[0], 1);
        tick(5);
        chk("single_stays_idle", busy_v[0], 0);
        // Held second bank and the refill come out in order once continuous.
        mode_v[0] = 1'b1;
        run_v[0]  = 1'b1;
        push_frame(0, 16, L);
        push_frame(0, 32, L);
        burst(0, 32, 16);
        drain(0, 200);
        chk("after_refill_cnt", cnt_v[0], 3);

        // Input stall after 40 samples: third frame waits for the fill.
        rst(0);
        mode_v[0] = 1'b1;
        run_v[0]  = 1'b1;
        c = cyc;
        push_frame(0, 0, L);
        push_frame(0, 16, L);
        push_frame(0, 32, L);
        push_start(0, c + 17);
        push_start(0, c + 33);
        burst(0, 0, 40);
        tick(40);
        chk("stall_frame_cnt", cnt_v[0], 2);
        chk("stall_in_ready", in_ready_v[0], 1);
        chk("stall_pending", q0.size(), 16);
        chk("stall_busy", busy_v[0], 0);
        d = cyc;
        push_start(0, d + 9);
        burst(0, 40, 8);
        drain(0, 200);
        chk("stall_final_cnt", cnt_v[0], 3);

        // Reset at read pointer 7 of the second frame.
        rst(0);
        mode_v[0] = 1'b1;
        run_v[0]  = 1'b1;
        c = cyc;
        push_frame(0, 0, L);
        push_frame(0, 16, 7);
        push_start(0, c + 17);
        push_start(0, c + 33);
        burst(0, 0, 39);
        reset_v[0] = 1'b1;
        tick(1);
        chk_reset_vals("midreset");
        chk("midreset_pending", q0.size(), 0);
        reset_v[0] = 1'b0;
        c = cyc;
        push_frame(0, 0, L);
        push_start(0, c + 17);
        burst(0, 0, 16);
        drain(0, 100);
        chk("post_reset_cnt", cnt_v[0], 1);

        // GAP=3 instance: start spacing 19 cycles.
        rst(1);
        mode_v[1] = 1'b1;
        run_v[1]  = 1'b1;
        c = cyc;
        push_frame(1, 0, L);
        push_frame(1, 16, L);
        push_frame(1, 32, L);
        push_start(1, c + 17);
        push_start(1, c + 36);
        push_start(1, c + 55);
        burst(1, 0, 48);
        drain(1, 300);
        chk("gap_frame_cnt", cnt_v[1], 3);
        chk("gap_last_valid", lastv[1], c + 70);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/fft_frame_sequencer.md
Name: fft_frame_sequencer

Overview:
- Synthesizable frame source that sits in front of the R2SDF FFT core (`fft`).
- Accepts a valid/ready sample stream and buffers it into ping-pong frame banks of 2^N samples.
- Drives the core's `start_ip`/`ip` interface with gap-free 2^N-sample frames, one sample per clock.
- Supports single-shot and continuous operation, a configurable inter-frame gap and a frame counter. This replaces the fixed, testbench-only array feed.

Parameters:
- N, 4: log2 of frame length; each bank holds 2^N samples.
- GAP, 0: idle cycles inserted between consecutive frames (0 = back-to-back).
- CNT_W, 16: width of frame counter.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  upstream sample valid
- in_ready  out  1  sequencer can accept sample
- in_data  in  fpt  upstream sample (fpt from sys_macro.vh)
- run  in  1  level enable; sampled in IDLE and at end of each frame/gap
- mode_cont  in  1  1 = continuous frames while run, 0 = one frame per run rising edge
- start_ip  out  1  one-cycle pulse coincident with first sample of frame
- ip  out  fpt  sample to FFT core, registered
- ip_valid  out  1  high for exactly 2^N consecutive cycles per frame
- busy  out  1  high in STREAM or GAP
- frame_cnt  out  CNT_W  frames fully emitted since reset, wraps at 2^CNT_W

Behaviour:
- Reset values:
  - start_ip=0, ip=0, ip_valid=0, busy=0, frame_cnt=0, in_ready=1.
  - Both banks empty; write bank 0, read bank 0; state IDLE.
  - Reset mid-frame aborts immediately and discards all buffered samples.
- Writer:
  - A sample is accepted when in_valid && in_ready. It is written at the write pointer; the pointer increments.
  - At pointer 2^N-1 the bank is marked full, the pointer wraps to 0 and the writer switches bank.
  - in_ready = !full[wbank].
- Reader FSM (IDLE, STREAM, GAP):
  - IDLE -> STREAM when full[rbank] && run, and either mode_cont=1 or a run rising edge is latched (edge latch set in any state, cleared on frame start).
  - STREAM: read pointer 0..2^N-1, one sample per cycle.
    - ip/ip_valid are registered: the first sample appears the cycle after the IDLE->STREAM decision, with start_ip=1 in that same cycle.
    - On the last sample: full[rbank] cleared, rbank toggles, frame_cnt increments.
    - Then -> GAP if GAP>0; else continue directly to the next frame's STREAM when the start condition holds (back-to-back, no bubble); else IDLE.
  - GAP: counts GAP cycles with ip_valid=0, then applies the same start condition.
- Boundary conditions:
  - Simultaneous writer-fill and reader-free of the same bank: the clear takes priority for the read side. The writer sees the bank free the next cycle.
  - Both banks full: in_ready=0, no samples lost.
  - run deasserted mid-frame: the frame completes, and the sequencer stops at the frame/gap end.
  - ip holds its last value when ip_valid=0.
- Throughput: continuous input at 1 sample/clk with GAP=0 yields continuous output after an initial 2^N+1 cycle latency.

Optional Feature:
- Macro: FFT_SEQ_BITREV_EN.
- Defined: the read address is the N-bit bit-reversal of the read pointer, so each frame is emitted in bit-reversed order for natural-order output cores. Timing and handshake are unchanged.
- Undefined: natural order, no reversal logic.

Decomposition:
- Package fft_seq_pkg holds:
  - the state enum (IDLE, STREAM, GAP);
  - the function bitrev(ptr, N);
  - the frame-length localparam FRAME = 1<<N.
- fpt and `CLK`/`CLKH` stay in sys_macro.vh.
- One sub-module: fft_seq_bank. It holds the two-bank storage, full flags, write pointer/bank logic and a registered read port. The top contains the reader FSM, gap counter, run-edge latch and frame counter.

Test Plan:
- N=4, GAP=0, mode_cont=1, run=1, feed 0..47 every cycle -> start_ip pulses at cycles 17, 33, 49; ip_valid continuous 48 cycles; ip=0..47 in order; frame_cnt=3.
- mode_cont=0, 32 samples buffered, one run pulse -> exactly one frame (ip 0..15), frame_cnt=1, second bank stays full, in_ready=1 for bank-0 refill.
- GAP=3, continuous feed -> 3 cycles ip_valid=0 between frames; start_ip spacing 19 cycles.
- Input stalled after 40 of 48 samples -> frames 1, 2 emitted, third not started; in_ready stays 1; then feed 8 more -> third frame starts next cycle after fill plus 1.
- Reset asserted at read pointer 7 of frame 2 -> next cycle all outputs at reset values; later feed 0..15 -> frame with ip 0..15, frame_cnt=1.
- FFT_SEQ_BITREV_EN, N=4, feed 0..15 -> ip sequence 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15.
